regfile_write_queue: RTL and testbench
======================================

Name: regfile_write_queue

Overview:
- Writer side of the physical register file's write port.
- Collects completed results from two execution-side producers into an in-order FIFO.
- Drains one result per cycle into the register file's single write port (select, data, commit strobe).
- Reports per-tag "write pending" hits so the operand read stage can detect values not yet in the register file.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 4
TAG_W, 6, register tag width; matches the 64-entry register file
DATA_W, 32, result data width

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
commitAllow  in  1  downstream permission to write the register file this cycle
wrReq0  in  1  producer 0 result valid
wrTag0  in  TAG_W  producer 0 destination tag
wrData0  in  DATA_W  producer 0 result
wrReq1  in  1  producer 1 result valid
wrTag1  in  TAG_W  producer 1 destination tag
wrData1  in  DATA_W  producer 1 result
wrAck  out  2  bit0 = producer 0 accepted, bit1 = producer 1 accepted (combinational)
writeCommit  out  1  registered; register file must write this cycle
writeSelect0  out  TAG_W  registered destination tag
writeData0  out  DATA_W  registered write data
readSelect0..2  in  TAG_W each  tags probed by the read stage
pendingHit  out  3  bit k = readSelectk matches a valid queued entry (combinational)
count  out  log2(DEPTH)+1  registered occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (reset low, asynchronous): count=0, head=tail=0, all entry valid bits cleared, writeCommit=0, writeSelect0=0, writeData0=0. wrAck and pendingHit are forced to 0 while reset is low.
- Acceptance uses registered count only. A same-cycle pop never frees space for a same-cycle push.
- free = DEPTH - count.
- wrAck[0] = wrReq0 & (free >= 1).
- wrAck[1] = wrReq1 & (free >= 2 when wrReq0, else free >= 1).
- Producers hold request, tag and data until acked.
- Enqueue order within one cycle: producer 0 entry at tail, producer 1 at tail+1. Pointers wrap modulo DEPTH.
- Pop condition: pop = commitAllow & ~empty.
- On a pop edge: writeCommit<=1, writeSelect0<=head tag, writeData0<=head data, head advances, head entry valid cleared.
- Without a pop: writeCommit<=0; writeSelect0 and writeData0 hold their last values.
- Latency: an entry pushed at edge N is the earliest pop candidate at edge N+1. writeCommit is high during cycle N+1..N+2, and the register file writes at edge N+2.
- count_next = count + acks - pop. Simultaneous push and pop on a full queue is legal: pop frees, pushes are already gated by free.
- pendingHit[k] = OR over valid entries of (tag == readSelectk).
- pendingHit also includes the entry currently presented on writeSelect0 while writeCommit=1, because the register file has not yet written it.
- Duplicate tags in the queue are legal. Drain order guarantees the youngest value lands last.
- commitAllow low for any number of cycles: queue holds; producers are back-pressured once full.
- Reset mid-operation: all queued results are discarded, and no writeCommit pulse follows reset release.
- No error states. A request while full is simply not acked.

Decomposition:
- Shared package: TAG_W, DATA_W, DEPTH defaults; an entry record type (valid, tag, data); a pointer-width constant derived from DEPTH.
- One natural sub-module: regfile_write_queue_cam, the combinational 3-port tag match over DEPTH entries plus the output stage. It produces pendingHit.
- Top level holds pointers, count, entry storage and the output register.

Test Plan:
- Reset: assert reset low mid-stream with 5 entries queued -> count=0, empty=1, writeCommit=0 immediately. After release, no writeCommit with commitAllow=1.
- Single path: commitAllow=1, wrReq0 tag 5, data 0xDEADBEEF at edge 0 -> writeCommit=1, writeSelect0=5, writeData0=0xDEADBEEF after edge 1, and 0 after edge 2.
- Dual push ordering: same cycle, tag 3/0x11 on port 0 and tag 3/0x22 on port 1 -> commits tag 3 with 0x11, then tag 3 with 0x22 on consecutive cycles.
- Full and back-pressure: commitAllow=0, both ports request every cycle -> wrAck=11 for 4 cycles, then 00, with full=1 and count=8. Raise commitAllow -> one pop per cycle. wrAck stays 00 in the first pop cycle and returns to 01 or 11 once space is registered.
- Wrap-around: push and pop 20 entries with tags 0..19 continuously -> commits in exact order 0..19, count never exceeds 8.
- Pending hit: queue holds tag 7, readSelect0=7, readSelect1=8, readSelect2=7 -> pendingHit=101. The hit on 7 persists through its writeCommit cycle and clears the cycle after.

Source files
------------

// File: rtl/regfile_write_queue_pkg.sv
// Shared constants and the entry record used by the register-file write queue.
package regfile_write_queue_pkg;

   localparam int RWQ_DEPTH  = 8;
   localparam int RWQ_TAG_W  = 6;
   localparam int RWQ_DATA_W = 32;
   localparam int RWQ_PTR_W  = $clog2(RWQ_DEPTH);

   // One queued result at the default widths: valid flag, destination tag, data.
   typedef struct packed {
      logic                  valid;
      logic [RWQ_TAG_W-1:0]  tag;
      logic [RWQ_DATA_W-1:0] data;
   } wqEntry_t;

endpackage

// File: rtl/regfile_write_queue_cam.sv
// Three-port tag match over all queued entries plus the entry currently being
// committed. It tells the operand read stage which tags are still in flight.
module regfile_write_queue_cam
   import regfile_write_queue_pkg::*;
#(
   parameter int DEPTH = RWQ_DEPTH,
   parameter int TAG_W = RWQ_TAG_W
) (
   input  logic                   reset,
   input  logic [DEPTH-1:0]       entryValid,
   input  logic [DEPTH*TAG_W-1:0] entryTags,
   input  logic                   commitValid,
   input  logic [TAG_W-1:0]       commitTag,
   input  logic [TAG_W-1:0]       readSelect0,
   input  logic [TAG_W-1:0]       readSelect1,
   input  logic [TAG_W-1:0]       readSelect2,
   output logic [2:0]             pendingHit
);

   logic [TAG_W-1:0] probes [3];
   logic             hit;

   // Match each probe against valid entries and the in-flight commit; gated off in reset.
   always_comb begin
      probes[0]  = readSelect0;
      probes[1]  = readSelect1;
      probes[2]  = readSelect2;
      pendingHit = '0;
      hit        = 1'b0;
      for (int k = 0; k < 3; k++) begin
         // The committing entry has left the queue but the register file has not written it yet.
         hit = commitValid && (commitTag == probes[k]);
         for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && (entryTags[i*TAG_W +: TAG_W] == probes[k])) begin
               hit = 1'b1;
            end
         end
         pendingHit[k] = reset & hit;
      end
   end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write queue in front of the register file's single write port.
// Two producers enqueue per cycle; one entry drains per cycle into a registered
// commit stage. Acceptance looks only at registered occupancy, so a pop never
// makes room for a push in the same cycle.
module regfile_write_queue
   import regfile_write_queue_pkg::*;
#(
   parameter int DEPTH  = RWQ_DEPTH,
   parameter int TAG_W  = RWQ_TAG_W,
   parameter int DATA_W = RWQ_DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     commitAllow,
   input  logic                     wrReq0,
   input  logic [TAG_W-1:0]         wrTag0,
   input  logic [DATA_W-1:0]        wrData0,
   input  logic                     wrReq1,
   input  logic [TAG_W-1:0]         wrTag1,
   input  logic [DATA_W-1:0]        wrData1,
   output logic [1:0]               wrAck,
   output logic                     writeCommit,
   output logic [TAG_W-1:0]         writeSelect0,
   output logic [DATA_W-1:0]        writeData0,
   input  logic [TAG_W-1:0]         readSelect0,
   input  logic [TAG_W-1:0]         readSelect1,
   input  logic [TAG_W-1:0]         readSelect2,
   output logic [2:0]               pendingHit,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t                 entries [DEPTH];
   logic [PTR_W-1:0]       head;
   logic [PTR_W-1:0]       tail;
   logic [PTR_W-1:0]       tailPort1;
   logic [CNT_W-1:0]       freeSlots;
   logic                   ack0;
   logic                   ack1;
   logic                   pop;
   logic [DEPTH-1:0]       validVec;
   logic [DEPTH*TAG_W-1:0] tagVec;

   // Acceptance and drain decisions from registered occupancy only.
   always_comb begin
      empty     = (count == '0);
      full      = (count == CNT_W'(DEPTH));
      freeSlots = CNT_W'(DEPTH) - count;
      ack0      = reset & wrReq0 & (freeSlots >= CNT_W'(1));
      ack1      = reset & wrReq1 &
                  (wrReq0 ? (freeSlots >= CNT_W'(2)) : (freeSlots >= CNT_W'(1)));
      wrAck     = {ack1, ack0};
      pop       = commitAllow & ~empty;
      // Producer 1 lands right behind producer 0 when both are accepted.
      tailPort1 = tail + PTR_W'(ack0);
   end

   // Queue storage, pointers, occupancy and the registered commit stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         writeCommit  <= 1'b0;
         writeSelect0 <= '0;
         writeData0   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         if (pop) begin
            writeCommit         <= 1'b1;
            writeSelect0        <= entries[head].tag;
            writeData0          <= entries[head].data;
            entries[head].valid <= 1'b0;
            head                <= head + PTR_W'(1);
         end else begin
            writeCommit <= 1'b0;
         end
         // Pushes never target the head slot while it pops: that needs a full queue, which blocks pushes.
         if (ack0) begin
            entries[tail] <= '{valid: 1'b1, tag: wrTag0, data: wrData0};
         end
         if (ack1) begin
            entries[tailPort1] <= '{valid: 1'b1, tag: wrTag1, data: wrData1};
         end
         tail  <= tail + PTR_W'(ack0) + PTR_W'(ack1);
         count <= count + CNT_W'(ack0) + CNT_W'(ack1) - CNT_W'(pop);
      end
   end

   // Flatten entry valid bits and tags for the match block.
   always_comb begin
      validVec = '0;
      tagVec   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         validVec[i]                = entries[i].valid;
         tagVec[i*TAG_W +: TAG_W]   = entries[i].tag;
      end
   end

   regfile_write_queue_cam #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) u_cam (
      .reset       (reset),
      .entryValid  (validVec),
      .entryTags   (tagVec),
      .commitValid (writeCommit),
      .commitTag   (writeSelect0),
      .readSelect0 (readSelect0),
      .readSelect1 (readSelect1),
      .readSelect2 (readSelect2),
      .pendingHit  (pendingHit)
   );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed and randomized checks of the write queue against a queue-based model.
module tb_regfile_write_queue;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                commitAllow;
  logic                wrReq0;
  logic [TAG_W-1:0]    wrTag0;
  logic [DATA_W-1:0]   wrData0;
  logic                wrReq1;
  logic [TAG_W-1:0]    wrTag1;
  logic [DATA_W-1:0]   wrData1;
  logic [1:0]          wrAck;
  logic                writeCommit;
  logic [TAG_W-1:0]    writeSelect0;
  logic [DATA_W-1:0]   writeData0;
  logic [TAG_W-1:0]    readSelect0;
  logic [TAG_W-1:0]    readSelect1;
  logic [TAG_W-1:0]    readSelect2;
  logic [2:0]          pendingHit;
  logic [3:0]          count;
  logic                full;
  logic                empty;

  // Reference model state
  ent_t                exp_q[$];
  logic                mCommit;
  logic [TAG_W-1:0]    mSel;
  logic [DATA_W-1:0]   mData;
  logic                lastAck0;
  logic                lastAck1;

  int nCompared = 0;
  int nMismatch = 0;
  int seen;

  regfile_write_queue dut (
    .clk          (clk),
    .reset        (reset),
    .commitAllow  (commitAllow),
    .wrReq0       (wrReq0),
    .wrTag0       (wrTag0),
    .wrData0      (wrData0),
    .wrReq1       (wrReq1),
    .wrTag1       (wrTag1),
    .wrData1      (wrData1),
    .wrAck        (wrAck),
    .writeCommit  (writeCommit),
    .writeSelect0 (writeSelect0),
    .writeData0   (writeData0),
    .readSelect0  (readSelect0),
    .readSelect1  (readSelect1),
    .readSelect2  (readSelect2),
    .pendingHit   (pendingHit),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    nCompared++;
    assert (obs === expv) else begin
      nMismatch++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    mCommit  = 1'b0;
    mSel     = '0;
    mData    = '0;
    lastAck0 = 1'b0;
    lastAck1 = 1'b0;
  endtask

  task automatic newPay0(input int maxTag);
    wrTag0  = TAG_W'($urandom_range(0, maxTag));
    wrData0 = $urandom;
  endtask

  task automatic newPay1(input int maxTag);
    wrTag1  = TAG_W'($urandom_range(0, maxTag));
    wrData1 = $urandom;
  endtask

  // One cycle: check all outputs against the model, take the edge, advance the model.
  task automatic step();
    int               freeSlots;
    logic             a0, a1, pop;
    logic [2:0]       hit;
    logic [TAG_W-1:0] sel;
    ent_t             e;
    #1;
    freeSlots = DEPTH - exp_q.size();
    a0  = wrReq0 && (freeSlots >= 1);
    a1  = wrReq1 && (wrReq0 ? (freeSlots >= 2) : (freeSlots >= 1));
    pop = commitAllow && (exp_q.size() > 0);
    for (int k = 0; k < 3; k++) begin
      sel = (k == 0) ? readSelect0 : ((k == 1) ? readSelect1 : readSelect2);
      hit[k] = mCommit && (mSel == sel);
      foreach (exp_q[i]) if (exp_q[i].tag == sel) hit[k] = 1'b1;
    end
    check("count",        64'(count),        64'(exp_q.size()));
    check("full",         64'(full),         64'(exp_q.size() == DEPTH));
    check("empty",        64'(empty),        64'(exp_q.size() == 0));
    check("writeCommit",  64'(writeCommit),  64'(mCommit));
    check("writeSelect0", 64'(writeSelect0), 64'(mSel));
    check("writeData0",   64'(writeData0),   64'(mData));
    check("wrAck",        64'(wrAck),        64'({a1, a0}));
    check("pendingHit",   64'(pendingHit),   64'(hit));
    @(posedge clk);
    if (pop) begin
      e = exp_q.pop_front();
      mCommit = 1'b1;
      mSel    = e.tag;
      mData   = e.data;
    end else begin
      mCommit = 1'b0;
    end
    if (a0) exp_q.push_back('{tag: wrTag0, data: wrData0});
    if (a1) exp_q.push_back('{tag: wrTag1, data: wrData1});
    lastAck0 = a0;
    lastAck1 = a1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; commitAllow = 1'b0;
    wrReq0 = 1'b1; wrTag0 = '0; wrData0 = '0;
    wrReq1 = 1'b1; wrTag1 = '0; wrData1 = '0;
    readSelect0 = '0; readSelect1 = '0; readSelect2 = '0;
    modelReset();

    // ---- reset state ----
    @(negedge clk);
    #1;
    check("rst_count",  64'(count),        64'(0));
    check("rst_empty",  64'(empty),        64'(1));
    check("rst_full",   64'(full),         64'(0));
    check("rst_commit", 64'(writeCommit),  64'(0));
    check("rst_sel",    64'(writeSelect0), 64'(0));
    check("rst_data",   64'(writeData0),   64'(0));
    check("rst_ack",    64'(wrAck),        64'(0));
    check("rst_hit",    64'(pendingHit),   64'(0));
    @(negedge clk);
    reset = 1'b1; wrReq0 = 1'b0; wrReq1 = 1'b0;

    // ---- single path ----
    commitAllow = 1'b1;
    wrReq0 = 1'b1; wrTag0 = 6'd5; wrData0 = 32'hDEADBEEF;
    step();
    wrReq0 = 1'b0;
    step();
    check("single_commit", 64'(writeCommit),  64'(1));
    check("single_sel",    64'(writeSelect0), 64'(5));
    check("single_data",   64'(writeData0),   64'(32'hDEADBEEF));
    step();
    check("single_commit_off", 64'(writeCommit), 64'(0));

    // ---- dual push ordering ----
    wrReq0 = 1'b1; wrTag0 = 6'd3; wrData0 = 32'h11;
    wrReq1 = 1'b1; wrTag1 = 6'd3; wrData1 = 32'h22;
    step();
    wrReq0 = 1'b0; wrReq1 = 1'b0;
    step();
    check("dual_first_sel",  64'(writeSelect0), 64'(3));
    check("dual_first_data", 64'(writeData0),   64'(32'h11));
    step();
    check("dual_second_commit", 64'(writeCommit), 64'(1));
    check("dual_second_data",   64'(writeData0),  64'(32'h22));
    step();
    check("dual_commit_off", 64'(writeCommit), 64'(0));

    // ---- full and back-pressure ----
    commitAllow = 1'b0;
    wrReq0 = 1'b1; wrReq1 = 1'b1; newPay0(63); newPay1(63);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_ack11", 64'(wrAck), 64'(2'b11));
      step();
      if (lastAck0) newPay0(63);
      if (lastAck1) newPay1(63);
    end
    #1;
    check("bp_ack00",  64'(wrAck), 64'(2'b00));
    check("bp_full",   64'(full),  64'(1));
    check("bp_count8", 64'(count), 64'(8));
    step();
    step();
    commitAllow = 1'b1;
    #1;
    check("bp_firstpop_ack00", 64'(wrAck), 64'(2'b00));
    step();
    #1;
    check("bp_space_ack01", 64'(wrAck), 64'(2'b01));
    check("bp_count7",      64'(count), 64'(7));
    for (int i = 0; i < 6; i++) begin
      step();
      if (lastAck0) newPay0(63);
      if (lastAck1) newPay1(63);
    end

    // ---- wrap-around ----
    wrReq0 = 1'b0; wrReq1 = 1'b0;
    for (int i = 0; i < 10; i++) step();
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      wrReq0 = (i < 20);
      wrTag0 = TAG_W'(i);
      wrData0 = $urandom;
      step();
      if (writeCommit === 1'b1) begin
        check("wrap_order", 64'(writeSelect0), 64'(seen));
        seen++;
      end
      check("wrap_count_bound", 64'(count <= 4'd8), 64'(1));
    end
    check("wrap_total", 64'(seen), 64'(20));

    // ---- pending hit ----
    commitAllow = 1'b0;
    wrReq0 = 1'b1; wrTag0 = 6'd7; wrData0 = $urandom;
    readSelect0 = 6'd7; readSelect1 = 6'd8; readSelect2 = 6'd7;
    step();
    wrReq0 = 1'b0;
    #1;
    check("hit_queued", 64'(pendingHit), 64'(3'b101));
    commitAllow = 1'b1;
    step();
    #1;
    check("hit_commit_cycle", 64'(writeCommit), 64'(1));
    check("hit_during_commit", 64'(pendingHit), 64'(3'b101));
    step();
    #1;
    check("hit_cleared", 64'(pendingHit), 64'(3'b000));

    // ---- randomized traffic ----
    for (int c = 0; c < 400; c++) begin
      if (!wrReq0 || lastAck0) begin wrReq0 = 1'($urandom_range(0, 1)); newPay0(15); end
      if (!wrReq1 || lastAck1) begin wrReq1 = 1'($urandom_range(0, 1)); newPay1(15); end
      commitAllow = ($urandom_range(0, 3) != 0);
      readSelect0 = TAG_W'($urandom_range(0, 15));
      readSelect1 = TAG_W'($urandom_range(0, 15));
      readSelect2 = TAG_W'($urandom_range(0, 15));
      step();
    end

    // ---- reset mid-operation ----
    wrReq0 = 1'b0; wrReq1 = 1'b0; commitAllow = 1'b1;
    for (int i = 0; i < 12; i++) step();
    commitAllow = 1'b0; wrReq0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      newPay0(63);
      step();
    end
    check("mid_count5", 64'(count), 64'(5));
    reset = 1'b0;
    #1;
    check("mid_rst_count",  64'(count),       64'(0));
    check("mid_rst_empty",  64'(empty),       64'(1));
    check("mid_rst_commit", 64'(writeCommit), 64'(0));
    check("mid_rst_ack",    64'(wrAck),       64'(0));
    check("mid_rst_hit",    64'(pendingHit),  64'(0));
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; wrReq0 = 1'b0; commitAllow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_commit", 64'(writeCommit), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
